// File: rtl/line_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_arbiter
// Description : Round-robin arbiter that shares one 256-bit line memory port
//               between the icache refill port and the dcache read/write-back
//               port. One transaction in flight. Address, write data and op
//               are registered at grant. A watchdog force-completes any
//               transaction whose memory ack never arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module line_fill_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int TO_BITS = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ic_addr_i,
    input  logic         ic_rd_i,
    output logic [255:0] ic_data_o,
    output logic         ic_ack_o,
    output logic         ic_fault_o,
    input  logic [31:0]  dc_addr_i,
    input  logic [255:0] dc_data_i,
    input  logic         dc_rd_i,
    input  logic         dc_wr_i,
    output logic [255:0] dc_data_o,
    output logic         dc_ack_o,
    output logic         dc_fault_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_rd_o,
    output logic         mem_wr_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    input  logic         mem_fault_i
);

    localparam logic [0:0]         c_ST_IDLE = 1'b0;
    localparam logic [0:0]         c_ST_BUSY = 1'b1;
    localparam logic [TO_BITS-1:0] c_WD_LAST = TO_BITS'(TIMEOUT - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               r_last_dc;    // 1: dcache was granted most recently
    logic               r_gnt_dc;     // 1: transaction in flight belongs to dcache
    logic [TO_BITS-1:0] r_wd;

    logic               w_ic_req;
    logic               w_dc_req;
    logic               w_grant;
    logic               w_grant_dc;
    logic               w_grant_wr;
    logic               w_timeout;
    logic               w_done;
    logic [255:0]       w_rsp_data;
    logic               w_rsp_fault;
    logic               w_unused_addr_bits;

    // Line addresses are 32-byte aligned, so the low bits are never forwarded.
    assign w_unused_addr_bits = ^{ic_addr_i[4:0], dc_addr_i[4:0]};

    assign w_ic_req   = ic_rd_i;
    assign w_dc_req   = dc_rd_i | dc_wr_i;
    assign w_grant    = (r_state == c_ST_IDLE) && (w_ic_req || w_dc_req);
    // On a tie the side that did not win last time gets the port.
    assign w_grant_dc = w_dc_req && (!w_ic_req || !r_last_dc);
    // A simultaneous read and write request resolves to the write.
    assign w_grant_wr = w_grant_dc && dc_wr_i;

    assign w_timeout  = (r_state == c_ST_BUSY) && (r_wd == c_WD_LAST);
    assign w_done     = (r_state == c_ST_BUSY) && (mem_ack_i || w_timeout);

    // Read data is forwarded only for a real ack on a read; write-backs and
    // watchdog completions return zero. A watchdog completion is a fault.
    assign w_rsp_data  = (mem_ack_i && mem_rd_o) ? mem_data_i : '0;
    assign w_rsp_fault = mem_ack_i ? mem_fault_i : 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE until someone asks, BUSY until ack or watchdog.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_ic_req || w_dc_req) w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (w_done)               w_state_nxt = c_ST_IDLE;
            default:                             w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Completion outputs: only the granted side ever sees ack, data or fault.
    always_comb begin
        ic_ack_o   = 1'b0;
        ic_data_o  = '0;
        ic_fault_o = 1'b0;
        dc_ack_o   = 1'b0;
        dc_data_o  = '0;
        dc_fault_o = 1'b0;
        if (w_done) begin
            if (r_gnt_dc) begin
                dc_ack_o   = 1'b1;
                dc_data_o  = w_rsp_data;
                dc_fault_o = w_rsp_fault;
            end else begin
                ic_ack_o   = 1'b1;
                ic_data_o  = w_rsp_data;
                ic_fault_o = w_rsp_fault;
            end
        end
    end

    // Memory-side request registers, grant bookkeeping and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_rd_o   <= 1'b0;
            mem_wr_o   <= 1'b0;
            r_last_dc  <= 1'b1;
            r_gnt_dc   <= 1'b0;
            r_wd       <= '0;
        end else if (w_grant) begin
            mem_addr_o <= w_grant_dc ? {dc_addr_i[31:5], 5'b0} : {ic_addr_i[31:5], 5'b0};
            mem_data_o <= w_grant_wr ? dc_data_i : '0;
            mem_rd_o   <= !w_grant_wr;
            mem_wr_o   <= w_grant_wr;
            r_last_dc  <= w_grant_dc;
            r_gnt_dc   <= w_grant_dc;
            r_wd       <= '0;
        end else if (w_done) begin
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_rd_o   <= 1'b0;
            mem_wr_o   <= 1'b0;
            r_wd       <= '0;
        end else if (r_state == c_ST_BUSY) begin
            r_wd       <= r_wd + 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Flag an illegal simultaneous dcache read and write request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(dc_rd_i && dc_wr_i))
                else $error("line_fill_arbiter: dc_rd_i and dc_wr_i both high");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_fill_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_line_fill_arbiter
// Description : Self-checking bench for line_fill_arbiter. Directed scenarios
//               followed by a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_arbiter;

    localparam int TIMEOUT = 16;
    localparam int TO_BITS = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ic_addr_i;
    logic         ic_rd_i;
    logic [255:0] ic_data_o;
    logic         ic_ack_o;
    logic         ic_fault_o;
    logic [31:0]  dc_addr_i;
    logic [255:0] dc_data_i;
    logic         dc_rd_i;
    logic         dc_wr_i;
    logic [255:0] dc_data_o;
    logic         dc_ack_o;
    logic         dc_fault_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_rd_o;
    logic         mem_wr_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         mem_fault_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_fill_arbiter #(.TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ic_addr_i  (ic_addr_i),
        .ic_rd_i    (ic_rd_i),
        .ic_data_o  (ic_data_o),
        .ic_ack_o   (ic_ack_o),
        .ic_fault_o (ic_fault_o),
        .dc_addr_i  (dc_addr_i),
        .dc_data_i  (dc_data_i),
        .dc_rd_i    (dc_rd_i),
        .dc_wr_i    (dc_wr_i),
        .dc_data_o  (dc_data_o),
        .dc_ack_o   (dc_ack_o),
        .dc_fault_o (dc_fault_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_rd_o   (mem_rd_o),
        .mem_wr_o   (mem_wr_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .mem_fault_i(mem_fault_i)
    );

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        ic_addr_i = '0; ic_rd_i = 1'b0;
        dc_addr_i = '0; dc_data_i = '0; dc_rd_i = 1'b0; dc_wr_i = 1'b0;
        mem_data_i = '0; mem_ack_i = 1'b0; mem_fault_i = 1'b0;
    endtask

    // Tasks start and end just after a rising edge (the drive point).
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        ic_rd_i = 1'b1; ic_addr_i = 32'hDEAD_BEEF; dc_wr_i = 1'b1; mem_ack_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({mem_rd_o, mem_wr_o, ic_ack_o, dc_ack_o, ic_fault_o, dc_fault_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_rd_o, mem_wr_o, ic_ack_o, dc_ack_o, ic_fault_o, dc_fault_o});
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr %h data %h expected 0", mem_addr_o, mem_data_o);
        end
        checks++;
        if (ic_data_o !== 256'h0 || dc_data_o !== 256'h0) begin
            errors++;
            $display("FAIL reset_data: got ic %h dc %h expected 0", ic_data_o, dc_data_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({mem_rd_o, mem_wr_o, ic_ack_o, dc_ack_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000", {mem_rd_o, mem_wr_o, ic_ack_o, dc_ack_o});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ic_read();
        ic_rd_i = 1'b1; ic_addr_i = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL ic_read_early: mem_rd_o got %b expected 0", mem_rd_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({mem_rd_o, mem_wr_o} !== 2'b10) begin
            errors++;
            $display("FAIL ic_read_op: got %b expected 10", {mem_rd_o, mem_wr_o});
        end
        checks++;
        if (mem_addr_o !== 32'h0000_1220 || mem_data_o !== 256'h0) begin
            errors++;
            $display("FAIL ic_read_bus: got addr %h data %h expected addr 00001220 data 0", mem_addr_o, mem_data_o);
        end
        @(posedge clk); #1;
        mem_ack_i = 1'b1; mem_data_i = {32{8'hA5}}; mem_fault_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({ic_ack_o, ic_fault_o, dc_ack_o, dc_fault_o} !== 4'b1000) begin
            errors++;
            $display("FAIL ic_read_ack: got %b expected 1000", {ic_ack_o, ic_fault_o, dc_ack_o, dc_fault_o});
        end
        checks++;
        if (ic_data_o !== {32{8'hA5}} || dc_data_o !== 256'h0) begin
            errors++;
            $display("FAIL ic_read_data: got ic %h dc %h expected ic a5.. dc 0", ic_data_o, dc_data_o);
        end
        @(posedge clk); #1;
        ic_rd_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
        @(negedge clk);
        checks++;
        if ({mem_rd_o, ic_ack_o} !== 2'b00 || ic_data_o !== 256'h0) begin
            errors++;
            $display("FAIL ic_read_release: got rd/ack %b data %h expected 00 / 0", {mem_rd_o, ic_ack_o}, ic_data_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        logic [31:0] exp_addr;
        int n;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            ic_rd_i = 1'b1; ic_addr_i = 32'h0000_0100 + 32'(r * 32'h1000);
            dc_rd_i = 1'b1; dc_addr_i = 32'h0000_0200 + 32'(r * 32'h1000);
            for (int k = 0; k < 2; k++) begin
                n = 0;
                @(negedge clk);
                while (mem_rd_o !== 1'b1 && n < 8) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (mem_rd_o !== 1'b1) begin
                    errors++;
                    $display("FAIL tie_grant_wait: round %0d slot %0d mem_rd_o got %b expected 1", r, k, mem_rd_o);
                end
                exp_addr = (k == 0) ? ic_addr_i : dc_addr_i;
                checks++;
                if (mem_addr_o !== exp_addr) begin
                    errors++;
                    $display("FAIL tie_order: round %0d slot %0d got addr %h expected %h", r, k, mem_addr_o, exp_addr);
                end
                @(posedge clk); #1;
                mem_ack_i = 1'b1; mem_data_i = rand256();
                @(negedge clk);
                checks++;
                if ({ic_ack_o, dc_ack_o} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL tie_ack: round %0d slot %0d got ic/dc %b", r, k, {ic_ack_o, dc_ack_o});
                end
                @(posedge clk); #1;
                mem_ack_i = 1'b0;
                if (k == 0) ic_rd_i = 1'b0;
                else        dc_rd_i = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_writeback();
        logic [255:0] pat;
        pat = rand256();
        dc_wr_i = 1'b1; dc_addr_i = 32'h8000_0040; dc_data_i = pat;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({mem_rd_o, mem_wr_o} !== 2'b01 || mem_addr_o !== 32'h8000_0040) begin
            errors++;
            $display("FAIL wb_op: got rd/wr %b addr %h expected 01 / 80000040", {mem_rd_o, mem_wr_o}, mem_addr_o);
        end
        checks++;
        if (mem_data_o !== pat) begin
            errors++;
            $display("FAIL wb_data: got %h expected %h", mem_data_o, pat);
        end
        @(posedge clk); #1;
        mem_ack_i = 1'b1; mem_data_i = ~pat; mem_fault_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({dc_ack_o, dc_fault_o, ic_ack_o} !== 3'b100 || dc_data_o !== 256'h0) begin
            errors++;
            $display("FAIL wb_ack: got ack/fault/ic %b data %h expected 100 / 0", {dc_ack_o, dc_fault_o, ic_ack_o}, dc_data_o);
        end
        @(posedge clk); #1;
        dc_wr_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
        @(negedge clk);
        checks++;
        if ({mem_wr_o, dc_ack_o} !== 2'b00 || mem_data_o !== 256'h0) begin
            errors++;
            $display("FAIL wb_release: got wr/ack %b data %h expected 00 / 0", {mem_wr_o, dc_ack_o}, mem_data_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fault();
        logic [255:0] d;
        d = rand256();
        ic_rd_i = 1'b1; ic_addr_i = 32'h0040_0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack_i = 1'b1; mem_fault_i = 1'b1; mem_data_i = d;
        @(negedge clk);
        checks++;
        if ({ic_ack_o, ic_fault_o, dc_ack_o, dc_fault_o} !== 4'b1100) begin
            errors++;
            $display("FAIL fault_flags: got %b expected 1100", {ic_ack_o, ic_fault_o, dc_ack_o, dc_fault_o});
        end
        checks++;
        if (ic_data_o !== d) begin
            errors++;
            $display("FAIL fault_data: got %h expected %h", ic_data_o, d);
        end
        @(posedge clk); #1;
        ic_rd_i = 1'b0; mem_ack_i = 1'b0; mem_fault_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        dc_rd_i = 1'b1; dc_addr_i = 32'h1234_5660;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 17) dc_rd_i = 1'b0;
            if (c == 20) begin mem_ack_i = 1'b1; mem_data_i = rand256(); end
            @(negedge clk);
            checks++;
            if ({dc_ack_o, dc_fault_o, ic_ack_o} !== ((c == TIMEOUT) ? 3'b110 : 3'b000)) begin
                errors++;
                $display("FAIL timeout_ack: cycle %0d got ack/fault/ic %b expected %b",
                         c, {dc_ack_o, dc_fault_o, ic_ack_o}, (c == TIMEOUT) ? 3'b110 : 3'b000);
            end
            checks++;
            if (dc_data_o !== 256'h0 || mem_rd_o !== (c <= TIMEOUT)) begin
                errors++;
                $display("FAIL timeout_bus: cycle %0d got mem_rd %b data %h", c, mem_rd_o, dc_data_o);
            end
        end
        @(posedge clk); #1;
        mem_ack_i = 1'b0; mem_data_i = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        ic_rd_i = 1'b1; ic_addr_i = 32'h0000_5000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: mem_rd_o got %b expected 1", mem_rd_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; ic_rd_i = 1'b0;
        dc_rd_i = 1'b1; dc_addr_i = 32'h0000_0040;
        @(negedge clk);
        checks++;
        if ({mem_rd_o, mem_wr_o, ic_ack_o, dc_ack_o} !== 4'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL midrst_abort: got %b addr %h expected 0000 / 0",
                     {mem_rd_o, mem_wr_o, ic_ack_o, dc_ack_o}, mem_addr_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h0000_0040) begin
            errors++;
            $display("FAIL midrst_regrant: got rd %b addr %h expected 1 / 00000040", mem_rd_o, mem_addr_o);
        end
        @(posedge clk); #1;
        mem_ack_i = 1'b1; mem_data_i = {8{32'h0BAD_F00D}};
        @(negedge clk);
        checks++;
        if (dc_ack_o !== 1'b1 || dc_data_o !== {8{32'h0BAD_F00D}}) begin
            errors++;
            $display("FAIL midrst_complete: got ack %b data %h", dc_ack_o, dc_data_o);
        end
        @(posedge clk); #1;
        dc_rd_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
        @(posedge clk); #1;
    endtask

    // Transaction-level model: one outstanding transfer, round-robin choice,
    // completion on ack or when the transfer is TIMEOUT cycles old.
    task automatic test_random(input int cycles);
        logic m_busy, m_dc, m_wr, m_last_dc, m_dead, done;
        int m_age;
        logic [31:0]  m_addr, exp_addr;
        logic [255:0] m_data, rsp_data;
        logic rsp_fault;
        do_reset();
        m_busy = 1'b0; m_dc = 1'b0; m_wr = 1'b0; m_last_dc = 1'b1; m_dead = 1'b0;
        m_age = 0; m_addr = '0; m_data = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            done      = m_busy && (mem_ack_i || m_age == TIMEOUT);
            exp_addr  = m_busy ? (m_addr & 32'hFFFF_FFE0) : 32'h0;
            rsp_data  = (done && mem_ack_i && !m_wr) ? mem_data_i : 256'h0;
            rsp_fault = done && (mem_ack_i ? mem_fault_i : 1'b1);
            checks++;
            if ({mem_rd_o, mem_wr_o} !== {m_busy && !m_wr, m_busy && m_wr}) begin
                errors++;
                $display("FAIL rnd_op: cycle %0d got %b expected %b", c, {mem_rd_o, mem_wr_o}, {m_busy && !m_wr, m_busy && m_wr});
            end
            checks++;
            if (mem_addr_o !== exp_addr) begin
                errors++;
                $display("FAIL rnd_addr: cycle %0d got %h expected %h", c, mem_addr_o, exp_addr);
            end
            checks++;
            if (mem_data_o !== (m_busy ? m_data : 256'h0)) begin
                errors++;
                $display("FAIL rnd_wdata: cycle %0d got %h expected %h", c, mem_data_o, m_busy ? m_data : 256'h0);
            end
            checks++;
            if ({ic_ack_o, ic_fault_o, dc_ack_o, dc_fault_o} !==
                {done && !m_dc, rsp_fault && !m_dc, done && m_dc, rsp_fault && m_dc}) begin
                errors++;
                $display("FAIL rnd_ack: cycle %0d got %b expected %b", c, {ic_ack_o, ic_fault_o, dc_ack_o, dc_fault_o},
                         {done && !m_dc, rsp_fault && !m_dc, done && m_dc, rsp_fault && m_dc});
            end
            checks++;
            if (ic_data_o !== (m_dc ? 256'h0 : rsp_data) || dc_data_o !== (m_dc ? rsp_data : 256'h0)) begin
                errors++;
                $display("FAIL rnd_rdata: cycle %0d got ic %h dc %h expected %h", c, ic_data_o, dc_data_o, rsp_data);
            end
            @(posedge clk);
            if (done) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_age++;
            end else if (ic_rd_i || dc_rd_i || dc_wr_i) begin
                m_dc      = (dc_rd_i || dc_wr_i) && (!ic_rd_i || !m_last_dc);
                m_last_dc = m_dc;
                m_busy    = 1'b1;
                m_age     = 1;
                m_wr      = m_dc && dc_wr_i;
                m_addr    = m_dc ? dc_addr_i : ic_addr_i;
                m_data    = m_wr ? dc_data_i : 256'h0;
                m_dead    = ($urandom_range(0, 5) == 0);
            end
            #1;
            if (done && !m_dc) begin
                ic_rd_i = 1'b0;
            end else if (!ic_rd_i && $urandom_range(0, 3) == 0) begin
                ic_rd_i = 1'b1; ic_addr_i = $urandom;
            end
            if (done && m_dc) begin
                dc_rd_i = 1'b0; dc_wr_i = 1'b0;
            end else if (!dc_rd_i && !dc_wr_i && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) dc_wr_i = 1'b1;
                else                           dc_rd_i = 1'b1;
                dc_addr_i = $urandom; dc_data_i = rand256();
            end
            mem_data_i  = rand256();
            mem_fault_i = ($urandom_range(0, 7) == 0);
            if (m_busy) mem_ack_i = !m_dead && ($urandom_range(0, 2) == 0);
            else        mem_ack_i = ($urandom_range(0, 9) == 0);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_tie();
        test_writeback();
        test_fault();
        test_timeout();
        test_mid_reset();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
